// File: rtl/cpu_controller_pkg.sv
// Shared encodings for the CPU control FSM: states, opcode/ext constants,
// ALU op, branch condition codes and PSR flag positions.
package cpu_controller_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_FETCH_WAIT,
    S_DECODE,
    S_EXEC,
    S_LD_ADDR,
    S_LD_WB,
    S_ST
  } state_t;

  localparam logic [3:0] OP_RTYPE  = 4'b0000;
  localparam logic [3:0] OP_MEM    = 4'b0100;
  localparam logic [3:0] OP_BCOND  = 4'b1100;
  localparam logic [3:0] OP_CMPI   = 4'b1011;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;
  localparam logic [3:0] EXT_CMP   = 4'b1011;

  localparam logic [5:0] ALU_ADD   = 6'h05;

  localparam logic [1:0] PC_SRC_ALU  = 2'd0;
  localparam logic [1:0] PC_SRC_REGB = 2'd1;
  localparam logic [1:0] PC_SRC_INC  = 2'd2;

  localparam logic [1:0] RWS_ALU = 2'd0;
  localparam logic [1:0] RWS_MEM = 2'd1;
  localparam logic [1:0] RWS_PC1 = 2'd2;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_HI = 4'h4;
  localparam logic [3:0] COND_LS = 4'h5;
  localparam logic [3:0] COND_GT = 4'h6;
  localparam logic [3:0] COND_LE = 4'h7;
  localparam logic [3:0] COND_FS = 4'h8;
  localparam logic [3:0] COND_FC = 4'h9;
  localparam logic [3:0] COND_LO = 4'hA;
  localparam logic [3:0] COND_HS = 4'hB;
  localparam logic [3:0] COND_LT = 4'hC;
  localparam logic [3:0] COND_GE = 4'hD;
  localparam logic [3:0] COND_UC = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int PSR_C = 0;
  localparam int PSR_L = 2;
  localparam int PSR_F = 5;
  localparam int PSR_Z = 6;
  localparam int PSR_N = 7;

endpackage

// File: rtl/cpu_controller_cond_eval.sv
// Branch/jump condition evaluator: condition code in A_index against PSR flags.
module cond_eval
  import cpu_controller_pkg::*;
#(
  parameter int REG_BITS = 4,
  parameter int WIDTH    = 16
) (
  input  logic [REG_BITS-1:0] A_index,
  input  logic [WIDTH-1:0]    psr_flags,
  output logic                taken
);

  logic c, l, f, z, n;
  logic unused_flags;

  assign c = psr_flags[PSR_C];
  assign l = psr_flags[PSR_L];
  assign f = psr_flags[PSR_F];
  assign z = psr_flags[PSR_Z];
  assign n = psr_flags[PSR_N];
  assign unused_flags = ^psr_flags;

  always_comb begin
    taken = 1'b0;
    case (4'(A_index))
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_HI: taken = l;
      COND_LS: taken = !l;
      COND_GT: taken = n;
      COND_LE: taken = !n;
      COND_FS: taken = f;
      COND_FC: taken = !f;
      COND_LO: taken = !l && !z;
      COND_HS: taken = l || z;
      COND_LT: taken = !n && !z;
      COND_GE: taken = n || z;
      COND_UC: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle control FSM: fetch over sync memory, decode, then exec/mem/writeback.
// Strobes are Moore outputs of state plus the instruction fields latched in DECODE.
module cpu_controller
  import cpu_controller_pkg::*;
#(
  parameter int ALU_CONT_BITS    = 6,
  parameter int OP_CODE_BITS     = 4,
  parameter int EXT_OP_CODE_BITS = 4,
  parameter int REG_BITS         = 4,
  parameter int WIDTH            = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [OP_CODE_BITS-1:0]     op_code,
  input  logic [EXT_OP_CODE_BITS-1:0] ext_op_code,
  input  logic [REG_BITS-1:0]         A_index,
  input  logic [WIDTH-1:0]            psr_flags,
  output logic                        reg_write,
  output logic                        alu_A_src,
  output logic                        alu_B_src,
  output logic                        pc_en,
  output logic [1:0]                  pc_src,
  output logic [1:0]                  reg_write_src,
  output logic                        loading,
  output logic                        storing,
  output logic                        mem_we,
  output logic                        instruction_en,
  output logic [ALU_CONT_BITS-1:0]    alu_cont,
  output logic                        instr_done
);

  state_t                      state, state_nxt;
  logic [OP_CODE_BITS-1:0]     op_q;
  logic [EXT_OP_CODE_BITS-1:0] ext_q;
  logic [REG_BITS-1:0]         cond_q;
  logic                        taken;

  cond_eval #(.REG_BITS(REG_BITS), .WIDTH(WIDTH)) u_cond (
    .A_index  (cond_q),
    .psr_flags(psr_flags),
    .taken    (taken)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_FETCH;
      op_q   <= '0;
      ext_q  <= '0;
      cond_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) begin
        op_q   <= op_code;
        ext_q  <= ext_op_code;
        cond_q <= A_index;
      end
    end
  end

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:      state_nxt = S_FETCH_WAIT;
      S_FETCH_WAIT: state_nxt = S_DECODE;
      S_DECODE: begin
        if (op_code == OP_MEM && ext_op_code == EXT_LOAD)      state_nxt = S_LD_ADDR;
        else if (op_code == OP_MEM && ext_op_code == EXT_STOR) state_nxt = S_ST;
        else                                                   state_nxt = S_EXEC;
      end
      S_LD_ADDR:    state_nxt = S_LD_WB;
      default:      state_nxt = S_FETCH;
    endcase
  end

  // Outputs are forced to their idle values while reset is high so an
  // aborted instruction cannot write on the reset edge.
  always_comb begin
    reg_write      = 1'b0;
    alu_A_src      = 1'b1;
    alu_B_src      = 1'b0;
    pc_en          = 1'b0;
    pc_src         = PC_SRC_INC;
    reg_write_src  = RWS_ALU;
    loading        = 1'b0;
    storing        = 1'b0;
    mem_we         = 1'b0;
    instruction_en = 1'b0;
    alu_cont       = '0;
    instr_done     = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH_WAIT: instruction_en = 1'b1;
        S_LD_ADDR:    loading = 1'b1;
        S_LD_WB: begin
          loading       = 1'b1;
          reg_write     = 1'b1;
          reg_write_src = RWS_MEM;
          pc_en         = 1'b1;
          instr_done    = 1'b1;
        end
        S_ST: begin
          storing    = 1'b1;
          mem_we     = 1'b1;
          pc_en      = 1'b1;
          instr_done = 1'b1;
        end
        S_EXEC: begin
          pc_en      = 1'b1;
          instr_done = 1'b1;
          if (op_q == OP_RTYPE) begin
            alu_cont  = ALU_CONT_BITS'({2'b00, ext_q});
            reg_write = (ext_q != EXT_CMP);
          end else if (op_q == OP_BCOND) begin
            alu_A_src = 1'b0;
            alu_B_src = 1'b1;
            alu_cont  = ALU_CONT_BITS'(ALU_ADD);
            pc_src    = taken ? PC_SRC_ALU : PC_SRC_INC;
          end else if (op_q == OP_MEM) begin
            // load/store never reach EXEC; anything else unlisted is a NOP
            case (ext_q)
              EXT_JAL: begin
                reg_write     = 1'b1;
                reg_write_src = RWS_PC1;
                pc_src        = PC_SRC_REGB;
              end
              EXT_JCOND: pc_src = taken ? PC_SRC_REGB : PC_SRC_INC;
              default: ;
            endcase
          end else begin
            alu_B_src = 1'b1;
            alu_cont  = ALU_CONT_BITS'({2'b01, op_q});
            reg_write = (op_q != OP_CMPI);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
